// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between pipeline WB (A) and mul/div (B), 1-cycle registered write, no buffering.
// Optional post-reset zero sweep of the RF when RF_WB_ARB_CLEAR_EN is defined (busy high, both readies low meanwhile).
module rf_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32,
    parameter int R0_PROT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
);

    logic              in_clear;
    logic [ADDR_W-1:0] clr_addr;

`ifdef RF_WB_ARB_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_ARB} state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(REG_NUM - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
                state_d = ST_ARB;
            end
        end
    end

    assign in_clear = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
`else
    assign in_clear = 1'b0;
    assign clr_addr = '0;
`endif

    // last_grant_q: 1 means B was granted most recently, so A wins the next conflict.
    logic              last_grant_q, last_grant_d;
    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              discard;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    assign grant_a  = !in_clear && a_valid && (!b_valid || last_grant_q);
    assign grant_b  = !in_clear && b_valid && (!a_valid || !last_grant_q);
    assign sel_addr = grant_b ? b_addr : a_addr;
    assign sel_data = grant_b ? b_data : a_data;
    assign discard  = (R0_PROT != 0) && (sel_addr == '0);

    always_comb begin
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        last_grant_d = last_grant_q;
        if (in_clear) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = clr_addr;
            rf_wdata_d = '0;
        end else if (grant_a || grant_b) begin
            last_grant_d = grant_b;
            // Writes to r0 still complete the handshake but never reach the RF.
            if (!discard) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = sel_addr;
                rf_wdata_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = in_clear;

endmodule
